// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the four requesters and the register-file arbiter.
//   req  [3:0]     : request, requester k = req[k]
//   sel  [11:0]    : target register index, requester k uses sel[3k+2:3k]
//   din  [4*DW-1:0]: write data, requester k uses din[DW*k +: DW]
//   gnt  [3:0]     : one-hot grant
//   load [7:0]     : one-hot load enables to register-file entries 0..7
//   dout [DW-1:0]  : shared write data to the register file
//   busy           : high while a grant is active
// master = requester side, slave = arbiter side.
interface rf_write_arbiter_if #(
  parameter int unsigned DW = 16
);
  logic [3:0]      req;
  logic [11:0]     sel;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [7:0]      load;
  logic [DW-1:0]   dout;
  logic            busy;

  modport master (output req, sel, din, input gnt, load, dout, busy);
  modport slave  (input req, sel, din, output gnt, load, dout, busy);
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter for the shared 8-entry dfrl register file.
// Grants one of four requesters at a time, registers its one-hot load enable
// and write data, and bounds a held grant to MAX_HOLD cycles while others wait.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : rf_write_arbiter_if.slave (req/sel/din in; gnt/load/dout/busy out)
module rf_write_arbiter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned SW   = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] load_q, load_d;
  logic [DW-1:0]   dout_q, dout_d;

  logic            grant_go;
  logic [1:0]      grant_who;
  logic [NREQ-1:0] others;
  logic [SW-1:0]   sel_w;
  logic [DW-1:0]   din_w;

  // First requester set in r, searching base, base+1, ... mod 4.
  function automatic logic [1:0] pick_winner(input logic [NREQ-1:0] r,
                                             input logic [1:0]      base);
    logic [1:0] w;
    logic [1:0] idx;
    logic       hit;
    w   = base;
    hit = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = base + 2'(i);
      if (!hit && r[idx]) begin
        w   = idx;
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  // Next-state, pointer, hold counter and next registered outputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    load_d    = '0;
    dout_d    = '0;
    grant_go  = 1'b0;
    grant_who = owner_q;
    sel_w     = '0;
    din_w     = '0;
    others    = bus.req & ~(NREQ'(1) << owner_q);

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_go  = 1'b1;
          grant_who = pick_winner(bus.req, ptr_q);
          cnt_d     = CW'(1);
        end
      end
      GRANT: begin
        if (!bus.req[owner_q] || (cnt_q == CW'(MAX_HOLD) && |others)) begin
          // Grant ends; hand over on the same edge if anyone else waits.
          ptr_d = owner_q + 2'd1;
          if (|others) begin
            grant_go  = 1'b1;
            grant_who = pick_winner(others, owner_q + 2'd1);
            cnt_d     = CW'(1);
          end
        end else begin
          grant_go  = 1'b1;
          grant_who = owner_q;
          if (cnt_q != CW'(MAX_HOLD)) cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    // Mux the winner's target index and data.
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant_who == 2'(k)) begin
        sel_w = bus.sel[SW*k +: SW];
        din_w = bus.din[DW*k +: DW];
      end
    end

    if (grant_go) begin
      state_d = GRANT;
      owner_d = grant_who;
      gnt_d   = NREQ'(1) << grant_who;
      load_d  = NREG'(1) << sel_w;
      dout_d  = din_w;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and output registers; reset wins over any grant in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      load_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.load = load_q;
  assign bus.dout = dout_q;
  assign bus.busy = (state_q == GRANT);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table for single-cycle
// behaviour plus hand-written rotation, reset-mid-grant and lone-holder runs.
module tb_rf_write_arbiter;

  localparam int DW = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rf_write_arbiter_if #(.DW(DW)) bus ();

  rf_write_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] sel;
    logic [63:0] din;
    logic [3:0]  e_gnt;
    logic [7:0]  e_load;
    logic [15:0] e_dout;
    logic        e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later, then check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
    chk("inv_load_onehot0", 64'($onehot0(bus.load)), 64'd1);
    chk("inv_gnt_vs_busy", 64'(bus.gnt != 4'd0), 64'(bus.busy));
    chk("inv_load_vs_busy", 64'(bus.load != 8'd0), 64'(bus.busy));
    if (!bus.busy) chk("inv_dout_idle", 64'(bus.dout), 64'd0);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic [7:0] l,
                            input logic [15:0] d, input logic b);
    chk({nm, "_gnt"},  64'(bus.gnt),  64'(g));
    chk({nm, "_load"}, 64'(bus.load), 64'(l));
    chk({nm, "_dout"}, 64'(bus.dout), 64'(d));
    chk({nm, "_busy"}, 64'(bus.busy), 64'(b));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.req = '0;
    bus.sel = '0;
    bus.din = '0;

    //            rst   req    sel      din                     gnt    load         dout     busy
    vecs[0]  = '{1'b1, 4'hF, 12'h000, 64'h4444_3333_2222_1111, 4'h0, 8'h00,       16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 12'h000, 64'h4444_3333_2222_1111, 4'h0, 8'h00,       16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 12'h000, 64'h4444_3333_2222_1111, 4'h1, 8'h01,       16'h1111, 1'b1};
    vecs[3]  = '{1'b0, 4'h0, 12'h000, 64'h0,                   4'h0, 8'h00,       16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 4'h4, 12'h140, 64'h0000_BEEF_0000_0000, 4'h4, 8'b0010_0000, 16'hBEEF, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 12'h140, 64'h0000_BEEF_0000_0000, 4'h0, 8'h00,       16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 4'h3, 12'h011, 64'h0000_0000_5555_AAAA, 4'h1, 8'h02,       16'hAAAA, 1'b1};
    vecs[7]  = '{1'b0, 4'h3, 12'h011, 64'h0000_0000_5555_AAAA, 4'h1, 8'h02,       16'hAAAA, 1'b1};
    vecs[8]  = '{1'b0, 4'h2, 12'h011, 64'h0000_0000_5555_AAAA, 4'h2, 8'h04,       16'h5555, 1'b1};
    vecs[9]  = '{1'b0, 4'hC, 12'hCD0, 64'hDDDD_CCCC_5555_0000, 4'h4, 8'h08,       16'hCCCC, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 12'h000, 64'h0,                   4'h0, 8'h00,       16'h0000, 1'b0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      reset   = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.sel = vecs[i].sel;
      bus.din = vecs[i].din;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_load,
                 vecs[i].e_dout, vecs[i].e_busy);
    end

    // All four requesting continuously: 4-cycle slots rotating 0,1,2,3,0.
    reset   = 1'b1;
    bus.req = 4'hF;
    step();
    step();
    reset   = 1'b0;
    bus.sel = 12'b110_100_010_000;
    bus.din = 64'h1003_1002_1001_1000;
    for (int c = 0; c < 20; c++) begin
      int o;
      o = (c / 4) % 4;
      step();
      expect_out($sformatf("rot%0d", c), 4'(1 << o), 8'(1 << (2 * o)),
                 16'(16'h1000 + o), 1'b1);
    end
    bus.req = 4'h0;
    step();
    expect_out("rot_release", 4'h0, 8'h00, 16'h0000, 1'b0);

    // Reset in the third cycle of a grant to requester 3.
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bus.req = 4'h8;
    bus.sel = 12'b100_000_000_000;
    bus.din = 64'h7777_0000_0000_0000;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_out($sformatf("r3_grant%0d", c), 4'h8, 8'h10, 16'h7777, 1'b1);
    end
    reset = 1'b1;
    step();
    expect_out("r3_in_reset", 4'h0, 8'h00, 16'h0000, 1'b0);
    reset = 1'b0;
    step();
    expect_out("r3_regrant", 4'h8, 8'h10, 16'h7777, 1'b1);

    // Lone requester 1 keeps the port; load tracks sel1 one cycle late.
    bus.req = 4'h2;
    for (int c = 0; c < 10; c++) begin
      bus.sel = (c < 5) ? 12'b000_000_000_000 : 12'b000_000_111_000;
      bus.din = 64'(32'(16'h6000 + c) << 16);
      step();
      expect_out($sformatf("lone%0d", c), 4'h2, (c < 5) ? 8'h01 : 8'h80,
                 16'(16'h6000 + c), 1'b1);
    end
    bus.req = 4'h0;
    step();
    expect_out("lone_release", 4'h0, 8'h00, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
